// File: rtl/rob_wr_arbiter_if.sv
// Request/RAM-write bundle for rob_wr_arbiter.
// master: drives writeback requests and the enqueue notice, observes grants and RAM writes.
// slave : the arbiter; grants requests and drives the RAM write ports.
//   req_valid/req_ready/req_addr/req_data : per-requester handshake and payload
//   enq_fire/enq_addr                     : RAM enqueue happening this cycle
//   wr_en/wr_addr/wr_data                 : per-port RAM write controls
interface rob_wr_arbiter_if #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned N_WRITE_PORTS = 2,
  parameter int unsigned N_ENTRIES     = 8,
  parameter int unsigned ENTRY_WIDTH   = 32
);
  localparam int unsigned PTR_WIDTH = $clog2(N_ENTRIES);

  logic [N_REQ-1:0]                          req_valid;
  logic [N_REQ-1:0]                          req_ready;
  logic [N_REQ-1:0][PTR_WIDTH-1:0]           req_addr;
  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]         req_data;
  logic                                      enq_fire;
  logic [PTR_WIDTH-1:0]                      enq_addr;
  logic [N_WRITE_PORTS-1:0]                  wr_en;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr;
  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data;

  modport master (
    output req_valid, req_addr, req_data, enq_fire, enq_addr,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, enq_fire, enq_addr,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rob_wr_arbiter.sv
// Round-robin arbiter sharing the ROB RAM write ports among writeback requesters.
// Grants up to N_WRITE_PORTS requests per cycle into a one-deep slot stage that
// drives the RAM; never issues two writes to one entry, nor a write to the entry
// being enqueued (such a slot is held and retried).
//   clk, rst_aL : clock, synchronous active-low reset
//   flush       : synchronous flush, drops slots and resets rr_ptr
//   bus         : requester handshake, enqueue notice, RAM write ports
//   rr_ptr      : current round-robin start index (debug)
module rob_wr_arbiter #(
  parameter int unsigned  N_REQ         = 4,
  parameter int unsigned  N_WRITE_PORTS = 2,
  parameter int unsigned  N_ENTRIES     = 8,
  parameter int unsigned  ENTRY_WIDTH   = 32,
  localparam int unsigned PTR_WIDTH     = $clog2(N_ENTRIES),
  localparam int unsigned RR_WIDTH      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_aL,
  input  logic                flush,
  rob_wr_arbiter_if.slave     bus,
  output logic [RR_WIDTH-1:0] rr_ptr
);

  logic [N_WRITE_PORTS-1:0]                  valid_q;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   addr_q;
  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] data_q;
  logic [RR_WIDTH-1:0]                       rr_q;

  logic [N_WRITE_PORTS-1:0]                  fire_c;
  logic [N_WRITE_PORTS-1:0]                  held_c;
  logic [N_WRITE_PORTS-1:0]                  fill_c;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   fill_addr_c;
  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] fill_data_c;
  logic [N_REQ-1:0]                          gnt_c;
  logic [RR_WIDTH-1:0]                       rr_n;
  logic                                      allow_c;

  int unsigned                               scan_idx;
  logic [RR_WIDTH-1:0]                       cur;
  logic                                      conflict;
  logic                                      taken;

  // A slot writes unless the RAM enqueues into the same entry this cycle.
  always_comb begin
    fire_c = '0;
    held_c = '0;
    for (int p = 0; p < N_WRITE_PORTS; p++) begin
      fire_c[p] = valid_q[p] & ~(bus.enq_fire & (bus.enq_addr == addr_q[p]));
      held_c[p] = valid_q[p] & ~fire_c[p];
    end
  end

  // Round-robin scan; each grant takes the lowest slot that is neither held nor already filled.
  always_comb begin
    gnt_c       = '0;
    fill_c      = '0;
    fill_addr_c = '0;
    fill_data_c = '0;
    rr_n        = rr_q;
    scan_idx    = 0;
    cur         = '0;
    conflict    = 1'b0;
    taken       = 1'b0;
    allow_c     = rst_aL & ~flush;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(rr_q) + 32'(k);
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      cur = RR_WIDTH'(scan_idx);
      // Next-cycle slot contents: held slots keep addr_q, filled slots take the granted address.
      conflict = 1'b0;
      for (int p = 0; p < N_WRITE_PORTS; p++) begin
        if ((held_c[p] && (addr_q[p] == bus.req_addr[cur])) ||
            (fill_c[p] && (fill_addr_c[p] == bus.req_addr[cur])))
          conflict = 1'b1;
      end
      taken = 1'b0;
      if (allow_c && bus.req_valid[cur] && !conflict) begin
        for (int p = 0; p < N_WRITE_PORTS; p++) begin
          if (!taken && !held_c[p] && !fill_c[p]) begin
            taken          = 1'b1;
            fill_c[p]      = 1'b1;
            fill_addr_c[p] = bus.req_addr[cur];
            fill_data_c[p] = bus.req_data[cur];
          end
        end
      end
      if (taken) begin
        gnt_c[cur] = 1'b1;
        rr_n       = (cur == RR_WIDTH'(N_REQ - 1)) ? '0 : cur + RR_WIDTH'(1);
      end
    end
  end

  assign bus.req_ready = gnt_c;
  assign bus.wr_en     = fire_c;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign rr_ptr        = rr_q;

  // Slot stage: held slots keep contents, granted requests refill free slots.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rr_q    <= '0;
    end else if (flush) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= held_c | fill_c;
      for (int p = 0; p < N_WRITE_PORTS; p++) begin
        if (fill_c[p]) begin
          addr_q[p] <= fill_addr_c[p];
          data_q[p] <= fill_data_c[p];
        end
      end
      rr_q <= rr_n;
    end
  end

endmodule

// File: tb/tb_rob_wr_arbiter.sv
// Directed bench for rob_wr_arbiter: reset, issue, fairness, address conflict,
// enqueue collision, flush and mid-operation reset.
module tb_rob_wr_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned NWP   = 2;
  localparam int unsigned NENT  = 8;
  localparam int unsigned EW    = 32;
  localparam int unsigned PW    = 3;
  localparam int unsigned RW    = 2;

  logic          clk = 1'b0;
  logic          rst_aL;
  logic          flush;
  logic [RW-1:0] rr_ptr;
  int            vectors     = 0;
  int            miscompares = 0;

  rob_wr_arbiter_if #(.N_REQ(N_REQ), .N_WRITE_PORTS(NWP), .N_ENTRIES(NENT), .ENTRY_WIDTH(EW)) bus ();

  rob_wr_arbiter #(.N_REQ(N_REQ), .N_WRITE_PORTS(NWP), .N_ENTRIES(NENT), .ENTRY_WIDTH(EW)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .flush  (flush),
    .bus    (bus),
    .rr_ptr (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Request payload encodes requester and address: {24'hDA7A00, 3'b0, idx, addr}.
  task automatic set_req(input logic [1:0] i, input logic v, input logic [PW-1:0] a);
    bus.req_valid[i] = v;
    bus.req_addr[i]  = a;
    bus.req_data[i]  = {24'hDA7A00, 3'b000, i, a};
  endtask

  // Drop all requests and flush so the next scenario starts with empty slots and rr_ptr = 0.
  task automatic quiesce();
    bus.req_valid = '0;
    bus.enq_fire  = 1'b0;
    flush         = 1'b1;
    settle();
    tick();
    flush = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst_aL = 1'b0;
    for (int i = 0; i < 4; i++) set_req(2'(i), 1'b1, 3'(i));
    tick();
    tick();
    settle();
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b exp %b", bus.req_ready, 4'b0000); end
    vectors++; if (bus.wr_en !== 2'b00) begin miscompares++; $display("FAIL reset_wr_en: got %b exp %b", bus.wr_en, 2'b00); end
    vectors++; if (bus.wr_addr !== 6'd0) begin miscompares++; $display("FAIL reset_wr_addr: got %h exp %h", bus.wr_addr, 6'd0); end
    vectors++; if (bus.wr_data !== 64'd0) begin miscompares++; $display("FAIL reset_wr_data: got %h exp %h", bus.wr_data, 64'd0); end
    vectors++; if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL reset_rr_ptr: got %0d exp %0d", rr_ptr, 0); end
    rst_aL = 1'b1;
    settle();
    vectors++; if (bus.req_ready !== 4'b0011) begin miscompares++; $display("FAIL release_ready: got %b exp %b", bus.req_ready, 4'b0011); end
    tick();
    settle();
    vectors++; if (bus.wr_en !== 2'b11) begin miscompares++; $display("FAIL release_wr_en: got %b exp %b", bus.wr_en, 2'b11); end
    vectors++; if (bus.wr_addr !== {3'd1, 3'd0}) begin miscompares++; $display("FAIL release_wr_addr: got %h exp %h", bus.wr_addr, {3'd1, 3'd0}); end
    vectors++; if (bus.req_ready !== 4'b1100) begin miscompares++; $display("FAIL release_ready2: got %b exp %b", bus.req_ready, 4'b1100); end
    vectors++; if (rr_ptr !== 2'd2) begin miscompares++; $display("FAIL release_rr_ptr: got %0d exp %0d", rr_ptr, 2); end
    quiesce();
  endtask

  task automatic test_basic_issue();
    set_req(2'd0, 1'b1, 3'd1);
    set_req(2'd1, 1'b1, 3'd2);
    set_req(2'd2, 1'b1, 3'd3);
    set_req(2'd3, 1'b0, 3'd0);
    settle();
    vectors++; if (bus.req_ready !== 4'b0011) begin miscompares++; $display("FAIL basic_ready0: got %b exp %b", bus.req_ready, 4'b0011); end
    tick();
    bus.req_valid = 4'b0100;
    settle();
    vectors++; if (bus.wr_en !== 2'b11) begin miscompares++; $display("FAIL basic_wr_en1: got %b exp %b", bus.wr_en, 2'b11); end
    vectors++; if (bus.wr_addr !== {3'd2, 3'd1}) begin miscompares++; $display("FAIL basic_wr_addr1: got %h exp %h", bus.wr_addr, {3'd2, 3'd1}); end
    vectors++; if (bus.wr_data !== {32'hDA7A000A, 32'hDA7A0001}) begin miscompares++; $display("FAIL basic_wr_data1: got %h exp %h", bus.wr_data, {32'hDA7A000A, 32'hDA7A0001}); end
    vectors++; if (rr_ptr !== 2'd2) begin miscompares++; $display("FAIL basic_rr1: got %0d exp %0d", rr_ptr, 2); end
    vectors++; if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL basic_ready1: got %b exp %b", bus.req_ready, 4'b0100); end
    tick();
    bus.req_valid = '0;
    settle();
    vectors++; if (bus.wr_en !== 2'b01) begin miscompares++; $display("FAIL basic_wr_en2: got %b exp %b", bus.wr_en, 2'b01); end
    vectors++; if (bus.wr_addr[0] !== 3'd3) begin miscompares++; $display("FAIL basic_wr_addr2: got %0d exp %0d", bus.wr_addr[0], 3); end
    vectors++; if (bus.wr_data[0] !== 32'hDA7A0013) begin miscompares++; $display("FAIL basic_wr_data2: got %h exp %h", bus.wr_data[0], 32'hDA7A0013); end
    vectors++; if (rr_ptr !== 2'd3) begin miscompares++; $display("FAIL basic_rr2: got %0d exp %0d", rr_ptr, 3); end
    quiesce();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) set_req(2'(i), 1'b1, 3'(4 + i));
    settle();
    vectors++; if (bus.req_ready !== 4'b0011) begin miscompares++; $display("FAIL fair_ready0: got %b exp %b", bus.req_ready, 4'b0011); end
    vectors++; if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL fair_rr0: got %0d exp %0d", rr_ptr, 0); end
    tick();
    settle();
    vectors++; if (bus.req_ready !== 4'b1100) begin miscompares++; $display("FAIL fair_ready1: got %b exp %b", bus.req_ready, 4'b1100); end
    vectors++; if (rr_ptr !== 2'd2) begin miscompares++; $display("FAIL fair_rr1: got %0d exp %0d", rr_ptr, 2); end
    vectors++; if (bus.wr_addr !== {3'd5, 3'd4}) begin miscompares++; $display("FAIL fair_wr_addr1: got %h exp %h", bus.wr_addr, {3'd5, 3'd4}); end
    tick();
    settle();
    vectors++; if (bus.req_ready !== 4'b0011) begin miscompares++; $display("FAIL fair_ready2: got %b exp %b", bus.req_ready, 4'b0011); end
    vectors++; if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL fair_rr2: got %0d exp %0d", rr_ptr, 0); end
    vectors++; if (bus.wr_en !== 2'b11) begin miscompares++; $display("FAIL fair_wr_en2: got %b exp %b", bus.wr_en, 2'b11); end
    vectors++; if (bus.wr_addr !== {3'd7, 3'd6}) begin miscompares++; $display("FAIL fair_wr_addr2: got %h exp %h", bus.wr_addr, {3'd7, 3'd6}); end
    quiesce();
  endtask

  task automatic test_addr_conflict();
    set_req(2'd0, 1'b1, 3'd5);
    set_req(2'd1, 1'b1, 3'd5);
    set_req(2'd2, 1'b1, 3'd6);
    set_req(2'd3, 1'b0, 3'd0);
    settle();
    vectors++; if (bus.req_ready !== 4'b0101) begin miscompares++; $display("FAIL conflict_ready0: got %b exp %b", bus.req_ready, 4'b0101); end
    tick();
    bus.req_valid = 4'b0010;
    settle();
    vectors++; if (bus.wr_en !== 2'b11) begin miscompares++; $display("FAIL conflict_wr_en: got %b exp %b", bus.wr_en, 2'b11); end
    vectors++; if (bus.wr_addr !== {3'd6, 3'd5}) begin miscompares++; $display("FAIL conflict_wr_addr: got %h exp %h", bus.wr_addr, {3'd6, 3'd5}); end
    vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL conflict_ready1: got %b exp %b", bus.req_ready, 4'b0010); end
    tick();
    bus.req_valid = '0;
    settle();
    vectors++; if (rr_ptr !== 2'd2) begin miscompares++; $display("FAIL conflict_rr: got %0d exp %0d", rr_ptr, 2); end
    quiesce();
  endtask

  task automatic test_enq_collision();
    set_req(2'd0, 1'b1, 3'd4);
    settle();
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL enq_ready0: got %b exp %b", bus.req_ready, 4'b0001); end
    tick();
    bus.req_valid = '0;
    set_req(2'd1, 1'b1, 3'd4);
    set_req(2'd2, 1'b1, 3'd2);
    bus.enq_fire = 1'b1;
    bus.enq_addr = 3'd4;
    settle();
    vectors++; if (bus.wr_en !== 2'b00) begin miscompares++; $display("FAIL enq_wr_en1: got %b exp %b", bus.wr_en, 2'b00); end
    vectors++; if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL enq_ready1: got %b exp %b", bus.req_ready, 4'b0100); end
    tick();
    bus.req_valid[2] = 1'b0;
    settle();
    vectors++; if (bus.wr_en !== 2'b10) begin miscompares++; $display("FAIL enq_wr_en2: got %b exp %b", bus.wr_en, 2'b10); end
    vectors++; if (bus.wr_addr[1] !== 3'd2) begin miscompares++; $display("FAIL enq_wr_addr2: got %0d exp %0d", bus.wr_addr[1], 2); end
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL enq_ready2: got %b exp %b", bus.req_ready, 4'b0000); end
    tick();
    bus.enq_fire = 1'b0;
    settle();
    vectors++; if (bus.wr_en !== 2'b01) begin miscompares++; $display("FAIL enq_wr_en3: got %b exp %b", bus.wr_en, 2'b01); end
    vectors++; if (bus.wr_addr[0] !== 3'd4) begin miscompares++; $display("FAIL enq_wr_addr3: got %0d exp %0d", bus.wr_addr[0], 4); end
    vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL enq_ready3: got %b exp %b", bus.req_ready, 4'b0010); end
    tick();
    quiesce();
  endtask

  task automatic test_flush();
    set_req(2'd0, 1'b1, 3'd1);
    set_req(2'd1, 1'b1, 3'd3);
    settle();
    tick();
    bus.req_valid = '0;
    set_req(2'd2, 1'b1, 3'd5);
    bus.enq_fire = 1'b1;
    bus.enq_addr = 3'd1;
    flush        = 1'b1;
    settle();
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL flush_ready: got %b exp %b", bus.req_ready, 4'b0000); end
    vectors++; if (bus.wr_en !== 2'b10) begin miscompares++; $display("FAIL flush_wr_en0: got %b exp %b", bus.wr_en, 2'b10); end
    tick();
    flush        = 1'b0;
    bus.enq_fire = 1'b0;
    settle();
    vectors++; if (bus.wr_en !== 2'b00) begin miscompares++; $display("FAIL flush_wr_en1: got %b exp %b", bus.wr_en, 2'b00); end
    vectors++; if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL flush_rr: got %0d exp %0d", rr_ptr, 0); end
    vectors++; if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL flush_ready1: got %b exp %b", bus.req_ready, 4'b0100); end
    tick();
    bus.req_valid = '0;
    settle();
    vectors++; if (bus.wr_en !== 2'b01) begin miscompares++; $display("FAIL flush_wr_en2: got %b exp %b", bus.wr_en, 2'b01); end
    vectors++; if (bus.wr_addr[0] !== 3'd5) begin miscompares++; $display("FAIL flush_wr_addr2: got %0d exp %0d", bus.wr_addr[0], 5); end
    tick();
    settle();
    vectors++; if (bus.wr_en !== 2'b00) begin miscompares++; $display("FAIL flush_wr_en3: got %b exp %b", bus.wr_en, 2'b00); end
    quiesce();
  endtask

  task automatic test_reset_midop();
    set_req(2'd0, 1'b1, 3'd2);
    settle();
    tick();
    bus.req_valid = '0;
    bus.enq_fire  = 1'b1;
    bus.enq_addr  = 3'd2;
    settle();
    vectors++; if (bus.wr_en !== 2'b00) begin miscompares++; $display("FAIL midrst_held: got %b exp %b", bus.wr_en, 2'b00); end
    rst_aL = 1'b0;
    tick();
    rst_aL       = 1'b1;
    bus.enq_fire = 1'b0;
    settle();
    vectors++; if (bus.wr_en !== 2'b00) begin miscompares++; $display("FAIL midrst_wr_en: got %b exp %b", bus.wr_en, 2'b00); end
    vectors++; if (bus.wr_addr !== 6'd0) begin miscompares++; $display("FAIL midrst_wr_addr: got %h exp %h", bus.wr_addr, 6'd0); end
    vectors++; if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL midrst_rr: got %0d exp %0d", rr_ptr, 0); end
    tick();
  endtask

  initial begin
    rst_aL        = 1'b0;
    flush         = 1'b0;
    bus.enq_fire  = 1'b0;
    bus.enq_addr  = '0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset();
    test_basic_issue();
    test_back_to_back();
    test_addr_conflict();
    test_enq_collision();
    test_flush();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
